// File: rtl/fifo_pack_pkg.sv
// Shared types for the FIFO lane packer: flush FSM states and the lane-keep helper.
// Combinational only; no timing or flow control lives here.
package fifo_pack_pkg;

   localparam int KEEP_MAX = 32;

   typedef enum logic [1:0] {
      FILL       = 2'd0,
      FLUSH_WAIT = 2'd1,
      FLUSH_EMIT = 2'd2
   } state_e;

   // Lanes below cnt are valid; cnt is clamped to ratio so a full beat gives all ones.
   function automatic logic [KEEP_MAX-1:0] keep_mask(input int cnt, input int ratio);
      logic [KEEP_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < KEEP_MAX; i++) begin
         m[i] = (i < cnt) && (i < ratio);
      end
      return m;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; registered read data one cycle after r_en.
// Writes are dropped when full, reads are ignored when empty.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         w_en,
   input  logic [W-1:0] din,
   output logic         full,
   input  logic         r_en,
   output logic [W-1:0] dout,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  dout_q;
   logic          do_w, do_r;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign do_w  = w_en && !full;
   assign do_r  = r_en && !empty;
   assign dout  = dout_q;

   always_ff @(posedge clk) begin
      if (do_w) begin
         mem_q[wp_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
      end else begin
         if (do_w) wp_q <= wp_q + AW'(1);
         if (do_r) begin
            rp_q   <= rp_q + AW'(1);
            dout_q <= mem_q[rp_q];
         end
         cnt_q <= cnt_q + CW'(do_w) - CW'(do_r);
      end
   end

endmodule

// File: rtl/fifo_pack_reader.sv
// Pops IN_W-bit FIFO words, packs RATIO lanes per beat onto a valid/ready stream; last pop to m_valid is 2 cycles.
// Pops stall whenever the accumulator would overflow behind a stalled output; flush emits a zero-padded partial beat.
module fifo_pack_reader
   import fifo_pack_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int RATIO = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [IN_W-1:0]       fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_r_en,
   output logic [IN_W*RATIO-1:0] m_data,
   output logic [RATIO-1:0]      m_keep,
   output logic                  m_valid,
   input  logic                  m_ready,
   input  logic                  flush,
   output logic                  flush_done
);

   localparam int OUT_W = IN_W * RATIO;
   localparam int CNT_W = $clog2(RATIO + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RATIO);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rd_pend_q;
   logic [OUT_W-1:0]   acc_q, acc_d;
   logic [OUT_W-1:0]   m_data_q, m_data_d;
   logic [RATIO-1:0]   m_keep_q, m_keep_d;
   logic               m_valid_q, m_valid_d;
   logic               flush_done_q, flush_done_d;

   logic [CNT_W-1:0]   fill, fill_eff;
   logic [OUT_W-1:0]   merged;
   logic               out_free, xfer_req, xfer;

   assign m_data     = m_data_q;
   assign m_keep     = m_keep_q;
   assign m_valid    = m_valid_q;
   assign flush_done = flush_done_q;

   // The word arriving this cycle is merged straight into the outgoing beat, so the
   // last lane leaves in its capture cycle and pops can run back-to-back across beats.
   always_comb begin
      fill   = cnt_q + CNT_W'(rd_pend_q);
      merged = acc_q;
      for (int i = 0; i < RATIO; i++) begin
         if (rd_pend_q && (cnt_q == CNT_W'(i))) begin
            merged[i*IN_W +: IN_W] = fifo_dout;
         end
      end
      out_free  = !m_valid_q || m_ready;
      xfer_req  = (fill == CNT_FULL) || ((state_q == FLUSH_EMIT) && (cnt_q != '0));
      xfer      = xfer_req && out_free;
      fill_eff  = xfer ? '0 : fill;
      fifo_r_en = rstn && (state_q == FILL) && !fifo_empty && !flush && (fill_eff < CNT_FULL);
   end

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_valid_d = m_valid_q;
      if (xfer) begin
         m_data_d  = merged;
         m_keep_d  = RATIO'(keep_mask(int'(fill), RATIO));
         m_valid_d = 1'b1;
         acc_d     = '0;
         cnt_d     = '0;
      end else begin
         if (m_ready) m_valid_d = 1'b0;
         if (rd_pend_q) begin
            acc_d = merged;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      case (state_q)
         FILL: begin
            if (flush) state_d = FLUSH_WAIT;
         end
         FLUSH_WAIT: begin
            if (!rd_pend_q) state_d = FLUSH_EMIT;
         end
         FLUSH_EMIT: begin
            if ((cnt_q == '0) || xfer) begin
               flush_done_d = 1'b1;
               state_d      = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= FILL;
         cnt_q        <= '0;
         rd_pend_q    <= 1'b0;
         acc_q        <= '0;
         m_data_q     <= '0;
         m_keep_q     <= '0;
         m_valid_q    <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rd_pend_q    <= fifo_r_en;
         acc_q        <= acc_d;
         m_data_q     <= m_data_d;
         m_keep_q     <= m_keep_d;
         m_valid_q    <= m_valid_d;
         flush_done_q <= flush_done_d;
      end
   end

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Directed bench: real FIFO upstream, scoreboard of expected beats, monitor on the falling edge.
module tb_fifo_pack_reader;

   localparam int IN_W  = 8;
   localparam int RATIO = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        fifo_rstn = 1'b0;
   logic        w_en = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        fifo_full, fifo_empty_raw, fifo_r_en;
   logic        empty_mask = 1'b0;
   logic        rd_empty;
   logic [7:0]  fifo_dout;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_valid, flush_done;
   logic        m_ready = 1'b0;
   logic        flush = 1'b0;

   always #5 clk = ~clk;

   assign rd_empty = fifo_empty_raw | empty_mask;

   sync_fifo #(.W(8), .DEPTH(16)) u_fifo (
      .clk   (clk),
      .rstn  (fifo_rstn),
      .w_en  (w_en),
      .din   (din),
      .full  (fifo_full),
      .r_en  (fifo_r_en),
      .dout  (fifo_dout),
      .empty (fifo_empty_raw)
   );

   fifo_pack_reader #(.IN_W(IN_W), .RATIO(RATIO)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .fifo_dout  (fifo_dout),
      .fifo_empty (rd_empty),
      .fifo_r_en  (fifo_r_en),
      .m_data     (m_data),
      .m_keep     (m_keep),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .flush      (flush),
      .flush_done (flush_done)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
   } beat_t;

   beat_t       sb[$];
   int          pop_cyc[$];
   int          cyc = 0;
   int          n_beats = 0;
   int          n_fd = 0;
   int          beat_cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        hold_prev = 1'b0;
   logic [31:0] prev_d = '0;
   logic [3:0]  prev_k = '0;
   logic [7:0]  bytes6 [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic monitor_step();
      beat_t e;
      cyc++;
      if (rstn) begin
         if (fifo_r_en) begin
            pop_cyc.push_back(cyc);
            chk("r_en_while_empty", 32'(rd_empty), 32'd0);
         end
         if (flush_done) n_fd++;
         if (hold_prev) begin
            chk("hold_data", m_data, prev_d);
            chk("hold_keep", 32'(m_keep), 32'(prev_k));
         end
         if (m_valid && m_ready) begin
            n_beats++;
            beat_cyc = cyc;
            chk("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("beat_data", m_data, e.d);
               chk("beat_keep", 32'(m_keep), 32'(e.k));
            end
         end
         hold_prev = m_valid && !m_ready;
         prev_d    = m_data;
         prev_k    = m_keep;
      end else begin
         hold_prev = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      w_en = 1'b1;
      din  = b;
      step();
      w_en = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int maxc);
      for (int i = 0; i < maxc && sb.size() != 0; i++) step();
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int base, b0, fd0, pushed;

      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none

      repeat (3) step();
      rstn      = 1'b1;
      fifo_rstn = 1'b1;
      @(negedge clk);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_keep", 32'(m_keep), 32'd0);
      chk("rst_m_data", m_data, 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      chk("rst_r_en", 32'(fifo_r_en), 32'd0);
      step();

      // 1: single full beat, back-to-back pops, 2-cycle pop-to-valid latency
      m_ready = 1'b1;
      base = pop_cyc.size();
      sb.push_back(beat_t'{32'h44332211, 4'hF});
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      wait_drain("t1_drain", 20);
      chk("t1_pops", 32'(pop_cyc.size() - base), 32'd4);
      if (pop_cyc.size() >= base + 4) begin
         chk("t1_consecutive", 32'(pop_cyc[base+3] - pop_cyc[base]), 32'd3);
         chk("t1_latency", 32'(beat_cyc - pop_cyc[base+3]), 32'd2);
      end

      // 2: stalled output holds beat, pops stop after the second beat fills
      m_ready = 1'b0;
      base = pop_cyc.size();
      b0   = n_beats;
      sb.push_back(beat_t'{32'h04030201, 4'hF});
      sb.push_back(beat_t'{32'h08070605, 4'hF});
      for (int i = 1; i <= 8; i++) push(8'(i));
      repeat (12) step();
      @(negedge clk);
      chk("t2_valid", 32'(m_valid), 32'd1);
      chk("t2_data", m_data, 32'h04030201);
      chk("t2_keep", 32'(m_keep), 32'hF);
      chk("t2_pops", 32'(pop_cyc.size() - base), 32'd8);
      chk("t2_fifo_empty", 32'(fifo_empty_raw), 32'd1);
      step();
      m_ready = 1'b1;
      wait_drain("t2_drain", 20);
      chk("t2_beats", 32'(n_beats - b0), 32'd2);

      // 3: partial flush
      fd0 = n_fd;
      b0  = n_beats;
      sb.push_back(beat_t'{32'h0000BBAA, 4'b0011});
      push(8'hAA); push(8'hBB);
      repeat (6) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      wait_drain("t3_drain", 20);
      repeat (4) step();
      chk("t3_flush_done", 32'(n_fd - fd0), 32'd1);
      chk("t3_beats", 32'(n_beats - b0), 32'd1);

      // 4: flush with nothing held
      fd0 = n_fd;
      b0  = n_beats;
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (8) step();
      chk("t4_flush_done", 32'(n_fd - fd0), 32'd1);
      chk("t4_beats", 32'(n_beats - b0), 32'd0);

      // 5: reset mid-beat with a word waiting in the FIFO
      b0 = n_beats;
      push(8'h55); push(8'h66);
      repeat (6) step();
      push(8'h9A);
      rstn = 1'b0;
      @(negedge clk);
      chk("t5_r_en_in_reset", 32'(fifo_r_en), 32'd0);
      chk("t5_fifo_has_word", 32'(fifo_empty_raw), 32'd0);
      step();
      rstn = 1'b1;
      @(negedge clk);
      chk("t5_m_valid", 32'(m_valid), 32'd0);
      chk("t5_m_data", m_data, 32'd0);
      chk("t5_m_keep", 32'(m_keep), 32'd0);
      chk("t5_flush_done", 32'(flush_done), 32'd0);
      step();
      sb.push_back(beat_t'{32'hF0DEBC9A, 4'hF});
      push(8'hBC); push(8'hDE); push(8'hF0);
      wait_drain("t5_drain", 20);
      chk("t5_beats", 32'(n_beats - b0), 32'd1);

      // 6: empty toggling every cycle, random backpressure, 64 bytes
      base = pop_cyc.size();
      for (int i = 0; i < 64; i++) bytes6[i] = 8'($urandom_range(0, 255));
      for (int j = 0; j < 16; j++) begin
         sb.push_back(beat_t'{{bytes6[4*j+3], bytes6[4*j+2], bytes6[4*j+1], bytes6[4*j]}, 4'hF});
      end
      pushed = 0;
      for (int c = 0; c < 3000 && pushed < 64; c++) begin
         empty_mask = ~empty_mask;
         m_ready    = 1'($urandom_range(0, 1));
         if (!fifo_full) begin
            w_en = 1'b1;
            din  = bytes6[pushed];
            pushed++;
         end else begin
            w_en = 1'b0;
         end
         step();
      end
      w_en = 1'b0;
      chk("t6_pushed", 32'(pushed), 32'd64);
      for (int c = 0; c < 2000 && sb.size() != 0; c++) begin
         empty_mask = ~empty_mask;
         m_ready    = 1'($urandom_range(0, 1));
         step();
      end
      empty_mask = 1'b0;
      m_ready    = 1'b1;
      wait_drain("t6_drain", 40);
      chk("t6_pops", 32'(pop_cyc.size() - base), 32'd64);

      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
